// File: rtl/idex_stage_reg_pkg.sv
// Shared pipeline-register definitions: control-field widths and the decoded control bundle.
// Every stage register imports this so the field layout stays consistent down the pipe.
package idex_stage_reg_pkg;

  localparam int unsigned RegW      = 5;
  localparam int unsigned AluOpW    = 3;
  localparam int unsigned StallCntW = 16;

  typedef struct packed {
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              alu_src;
    logic              reg_dst;
    logic [AluOpW-1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/pipe_dff_en.sv
// Generic pipeline field register: async reset, synchronous clear-to-bubble, load enable.
// Clear wins over enable so a squashed slot never picks up the incoming instruction.
module pipe_dff_en #(
  parameter int unsigned W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection and a saturating bubble counter.
// A stall or a flush both load a bubble; flush suppresses the stall so it is never counted.
module idex_stage_reg
  import idex_stage_reg_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = RegW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_W-1:0]     IFID_Rs,
  input  logic [REG_W-1:0]     IFID_Rt,
  input  logic [REG_W-1:0]     IFID_Rd,
  input  logic                 ID_UsesRt,
  input  logic                 ID_RegWrite,
  input  logic                 ID_MemRead,
  input  logic                 ID_MemWrite,
  input  logic                 ID_MemToReg,
  input  logic                 ID_ALUSrc,
  input  logic                 ID_RegDst,
  input  logic [AluOpW-1:0]    ID_ALUOp,
  input  logic [DATA_W-1:0]    ID_A,
  input  logic [DATA_W-1:0]    ID_B,
  input  logic [DATA_W-1:0]    ID_Imm,
  input  logic                 ID_Valid,
  input  logic                 Flush,
  output logic [REG_W-1:0]     IDEX_Rs,
  output logic [REG_W-1:0]     IDEX_Rt,
  output logic [REG_W-1:0]     IDEX_Rd,
  output logic                 IDEX_RegWrite,
  output logic                 IDEX_MemRead,
  output logic                 IDEX_MemWrite,
  output logic                 IDEX_MemToReg,
  output logic                 IDEX_ALUSrc,
  output logic                 IDEX_RegDst,
  output logic [AluOpW-1:0]    IDEX_ALUOp,
  output logic [DATA_W-1:0]    IDEX_A,
  output logic [DATA_W-1:0]    IDEX_B,
  output logic [DATA_W-1:0]    IDEX_Imm,
  output logic                 IDEX_Valid,
  output logic                 Stall,
  output logic [StallCntW-1:0] StallCount
);

  logic                 w_bubble;
  logic                 w_hazard;
  logic [REG_W-1:0]     w_xnor_rs;
  logic [REG_W-1:0]     w_xnor_rt;
  logic                 w_rt_eq_rs;
  logic                 w_rt_eq_rt;
  logic                 w_rt_nz;
  logic [3*REG_W-1:0]   w_regs_d;
  logic [3*REG_W-1:0]   w_regs_q;
  ctrl_t                w_ctrl_d;
  ctrl_t                w_ctrl_q;
  logic [3*DATA_W-1:0]  w_data_d;
  logic [3*DATA_W-1:0]  w_data_q;
  logic                 w_valid_q;
  logic [StallCntW-1:0] r_stall_count;

  // Same xnor/AND equality structure as the forwarding unit's comparators.
  assign w_xnor_rs  = IDEX_Rt ~^ IFID_Rs;
  assign w_xnor_rt  = IDEX_Rt ~^ IFID_Rt;
  assign w_rt_eq_rs = &w_xnor_rs;
  assign w_rt_eq_rt = &w_xnor_rt;
  assign w_rt_nz    = |IDEX_Rt;

  assign w_hazard = IDEX_Valid & IDEX_MemRead & w_rt_nz &
                    (w_rt_eq_rs | (ID_UsesRt & w_rt_eq_rt)) & ID_Valid;
  assign Stall    = w_hazard & ~Flush;
  assign w_bubble = Stall | Flush;

  assign w_regs_d = {IFID_Rs, IFID_Rt, IFID_Rd};
  assign w_ctrl_d = '{reg_write:  ID_RegWrite,
                      mem_read:   ID_MemRead,
                      mem_write:  ID_MemWrite,
                      mem_to_reg: ID_MemToReg,
                      alu_src:    ID_ALUSrc,
                      reg_dst:    ID_RegDst,
                      alu_op:     ID_ALUOp};
  assign w_data_d = {ID_A, ID_B, ID_Imm};

  pipe_dff_en #(.W(3*REG_W)) u_regs (
    .i_clk (clk),
    .i_rst (rst),
    .i_en  (1'b1),
    .i_clr (w_bubble),
    .i_d   (w_regs_d),
    .o_q   (w_regs_q)
  );

  pipe_dff_en #(.W($bits(ctrl_t))) u_ctrl (
    .i_clk (clk),
    .i_rst (rst),
    .i_en  (1'b1),
    .i_clr (w_bubble),
    .i_d   (w_ctrl_d),
    .o_q   (w_ctrl_q)
  );

  pipe_dff_en #(.W(3*DATA_W)) u_data (
    .i_clk (clk),
    .i_rst (rst),
    .i_en  (1'b1),
    .i_clr (w_bubble),
    .i_d   (w_data_d),
    .o_q   (w_data_q)
  );

  pipe_dff_en #(.W(1)) u_valid (
    .i_clk (clk),
    .i_rst (rst),
    .i_en  (1'b1),
    .i_clr (w_bubble),
    .i_d   (ID_Valid),
    .o_q   (w_valid_q)
  );

  assign {IDEX_Rs, IDEX_Rt, IDEX_Rd} = w_regs_q;
  assign {IDEX_A, IDEX_B, IDEX_Imm}  = w_data_q;
  assign IDEX_RegWrite = w_ctrl_q.reg_write;
  assign IDEX_MemRead  = w_ctrl_q.mem_read;
  assign IDEX_MemWrite = w_ctrl_q.mem_write;
  assign IDEX_MemToReg = w_ctrl_q.mem_to_reg;
  assign IDEX_ALUSrc   = w_ctrl_q.alu_src;
  assign IDEX_RegDst   = w_ctrl_q.reg_dst;
  assign IDEX_ALUOp    = w_ctrl_q.alu_op;
  assign IDEX_Valid    = w_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_count <= '0;
    end else if (Stall && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + StallCntW'(1);
    end
  end

  assign StallCount = r_stall_count;

endmodule

// File: tb/tb_idex_stage_reg.sv
// Bench for idex_stage_reg: directed cycle table, randomized traffic against a reference model,
// mid-cycle reset and bubble-counter saturation.
module tb_idex_stage_reg;

  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] IFID_Rs, IFID_Rt, IFID_Rd;
  logic          ID_UsesRt, ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg;
  logic          ID_ALUSrc, ID_RegDst, ID_Valid, Flush;
  logic [2:0]    ID_ALUOp;
  logic [DW-1:0] ID_A, ID_B, ID_Imm;
  logic [RW-1:0] IDEX_Rs, IDEX_Rt, IDEX_Rd;
  logic          IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_MemToReg;
  logic          IDEX_ALUSrc, IDEX_RegDst, IDEX_Valid, Stall;
  logic [2:0]    IDEX_ALUOp;
  logic [DW-1:0] IDEX_A, IDEX_B, IDEX_Imm;
  logic [15:0]   StallCount;

  idex_stage_reg #(.DATA_W(DW), .REG_W(RW)) dut (
    .clk           (clk),
    .rst           (rst),
    .IFID_Rs       (IFID_Rs),
    .IFID_Rt       (IFID_Rt),
    .IFID_Rd       (IFID_Rd),
    .ID_UsesRt     (ID_UsesRt),
    .ID_RegWrite   (ID_RegWrite),
    .ID_MemRead    (ID_MemRead),
    .ID_MemWrite   (ID_MemWrite),
    .ID_MemToReg   (ID_MemToReg),
    .ID_ALUSrc     (ID_ALUSrc),
    .ID_RegDst     (ID_RegDst),
    .ID_ALUOp      (ID_ALUOp),
    .ID_A          (ID_A),
    .ID_B          (ID_B),
    .ID_Imm        (ID_Imm),
    .ID_Valid      (ID_Valid),
    .Flush         (Flush),
    .IDEX_Rs       (IDEX_Rs),
    .IDEX_Rt       (IDEX_Rt),
    .IDEX_Rd       (IDEX_Rd),
    .IDEX_RegWrite (IDEX_RegWrite),
    .IDEX_MemRead  (IDEX_MemRead),
    .IDEX_MemWrite (IDEX_MemWrite),
    .IDEX_MemToReg (IDEX_MemToReg),
    .IDEX_ALUSrc   (IDEX_ALUSrc),
    .IDEX_RegDst   (IDEX_RegDst),
    .IDEX_ALUOp    (IDEX_ALUOp),
    .IDEX_A        (IDEX_A),
    .IDEX_B        (IDEX_B),
    .IDEX_Imm      (IDEX_Imm),
    .IDEX_Valid    (IDEX_Valid),
    .Stall         (Stall),
    .StallCount    (StallCount)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the instruction the EX stage should currently hold.
  typedef struct packed {
    logic [RW-1:0] rs, rt, rd;
    logic          rw, mr, mw, m2r, asrc, rdst;
    logic [2:0]    op;
    logic [DW-1:0] a, b, imm;
    logic          v;
  } slot_t;

  slot_t       m_ex;
  logic [15:0] m_cnt;

  typedef struct {
    logic v, fl, ur, mr, mw, rw;
    int   rs, rt;
    logic e_stall, e_valid;
    int   e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void vec(input logic v, fl, ur, mr, mw, rw, input int rs, rt,
                              input logic es, ev, input int ec);
    vec_t t;
    t.v = v; t.fl = fl; t.ur = ur; t.mr = mr; t.mw = mw; t.rw = rw;
    t.rs = rs; t.rt = rt; t.e_stall = es; t.e_valid = ev; t.e_cnt = ec;
    tbl.push_back(t);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // A load in EX blocks the ID instruction if ID reads the load's (non-zero) target.
  function automatic logic model_stall();
    logic dep;
    dep = (m_ex.rt == IFID_Rs) || (ID_UsesRt && (m_ex.rt == IFID_Rt));
    return m_ex.v && m_ex.mr && (m_ex.rt != 0) && dep && ID_Valid && !Flush;
  endfunction

  task automatic check_outs(input string tag);
    check({tag, ".Rs"},    64'(IDEX_Rs),       64'(m_ex.rs));
    check({tag, ".Rt"},    64'(IDEX_Rt),       64'(m_ex.rt));
    check({tag, ".Rd"},    64'(IDEX_Rd),       64'(m_ex.rd));
    check({tag, ".RegWr"}, 64'(IDEX_RegWrite), 64'(m_ex.rw));
    check({tag, ".MemRd"}, 64'(IDEX_MemRead),  64'(m_ex.mr));
    check({tag, ".MemWr"}, 64'(IDEX_MemWrite), 64'(m_ex.mw));
    check({tag, ".M2R"},   64'(IDEX_MemToReg), 64'(m_ex.m2r));
    check({tag, ".ASrc"},  64'(IDEX_ALUSrc),   64'(m_ex.asrc));
    check({tag, ".RDst"},  64'(IDEX_RegDst),   64'(m_ex.rdst));
    check({tag, ".ALUOp"}, 64'(IDEX_ALUOp),    64'(m_ex.op));
    check({tag, ".A"},     64'(IDEX_A),        64'(m_ex.a));
    check({tag, ".B"},     64'(IDEX_B),        64'(m_ex.b));
    check({tag, ".Imm"},   64'(IDEX_Imm),      64'(m_ex.imm));
    check({tag, ".Valid"}, 64'(IDEX_Valid),    64'(m_ex.v));
    check({tag, ".Cnt"},   64'(StallCount),    64'(m_cnt));
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic do_cycle(input string tag);
    logic s;
    s = model_stall();
    #1;
    check({tag, ".Stall"}, 64'(Stall), 64'(s));
    @(posedge clk);
    if (s || Flush) begin
      m_ex = '0;
    end else begin
      m_ex = '{rs: IFID_Rs, rt: IFID_Rt, rd: IFID_Rd, rw: ID_RegWrite, mr: ID_MemRead,
               mw: ID_MemWrite, m2r: ID_MemToReg, asrc: ID_ALUSrc, rdst: ID_RegDst,
               op: ID_ALUOp, a: ID_A, b: ID_B, imm: ID_Imm, v: ID_Valid};
    end
    if (s && (m_cnt != 16'hFFFF)) m_cnt = m_cnt + 16'd1;
    #1;
    check_outs(tag);
    @(negedge clk);
  endtask

  task automatic rand_payload();
    IFID_Rd     = RW'($urandom);
    ID_MemToReg = 1'($urandom);
    ID_ALUSrc   = 1'($urandom);
    ID_RegDst   = 1'($urandom);
    ID_ALUOp    = 3'($urandom);
    ID_A        = $urandom;
    ID_B        = $urandom;
    ID_Imm      = $urandom;
  endtask

  task automatic drive_instr(input logic v, fl, ur, mr, mw, rw, input int rs, rt);
    rand_payload();
    ID_Valid = v; Flush = fl; ID_UsesRt = ur; ID_MemRead = mr; ID_MemWrite = mw;
    ID_RegWrite = rw; IFID_Rs = RW'(rs); IFID_Rt = RW'(rt);
  endtask

  initial begin
    // {valid, flush, usesRt, memRd, memWr, regWr, rs, rt} -> {stall, next valid, next count}
    vec(1, 0, 0, 1, 0, 1,  1,  8, 0, 1, 0);  // lw $8
    vec(1, 0, 1, 0, 0, 1,  8,  2, 1, 0, 1);  // add uses $8: bubble
    vec(1, 0, 1, 0, 0, 1,  8,  2, 0, 1, 1);  // add held, now captured
    vec(1, 0, 0, 1, 0, 1,  3,  0, 0, 1, 1);  // lw $0
    vec(1, 0, 1, 0, 0, 1,  0,  5, 0, 1, 1);  // reads $0: no stall
    vec(1, 0, 0, 1, 0, 1,  4,  9, 0, 1, 1);  // lw $9
    vec(1, 0, 0, 0, 1, 0,  5,  9, 0, 1, 1);  // sw, Rt not a source
    vec(1, 0, 0, 1, 0, 1,  4,  9, 0, 1, 1);  // lw $9 again
    vec(1, 0, 1, 0, 1, 0,  5,  9, 1, 0, 2);  // sw, Rt is a source
    vec(1, 0, 1, 0, 1, 0,  5,  9, 0, 1, 2);
    vec(1, 0, 0, 1, 0, 1,  1,  7, 0, 1, 2);  // lw $7
    vec(1, 1, 0, 0, 0, 1,  7,  2, 0, 0, 2);  // hazard but flushed
    vec(1, 0, 0, 0, 0, 1,  7,  2, 0, 1, 2);
    vec(1, 0, 0, 1, 0, 1,  1, 10, 0, 1, 2);  // lw $10
    vec(1, 0, 0, 1, 0, 1, 10, 11, 1, 0, 3);  // lw $11 <- $10
    vec(1, 0, 0, 1, 0, 1, 10, 11, 0, 1, 3);
    vec(1, 0, 0, 0, 0, 1, 11,  3, 1, 0, 4);  // add <- $11
    vec(1, 0, 0, 0, 0, 1, 11,  3, 0, 1, 4);
    vec(0, 0, 0, 1, 0, 1, 11, 12, 0, 0, 4);  // invalid slot, controls captured
    vec(1, 0, 0, 0, 0, 1, 12,  3, 0, 1, 4);  // invalid load in EX: no stall

    rst = 1'b1;
    drive_instr(0, 0, 0, 0, 0, 0, 0, 0);
    m_ex  = '0;
    m_cnt = '0;
    #1;
    check("reset.Stall", 64'(Stall), 64'd0);
    check_outs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive_instr(tbl[i].v, tbl[i].fl, tbl[i].ur, tbl[i].mr, tbl[i].mw, tbl[i].rw,
                  tbl[i].rs, tbl[i].rt);
      #1;
      check($sformatf("tbl%0d.stall", i), 64'(Stall), 64'(tbl[i].e_stall));
      do_cycle($sformatf("tbl%0d", i));
      check($sformatf("tbl%0d.valid", i), 64'(IDEX_Valid), 64'(tbl[i].e_valid));
      check($sformatf("tbl%0d.cnt", i), 64'(StallCount), 64'(tbl[i].e_cnt));
    end

    // Small register range keeps dependences frequent.
    for (int n = 0; n < 400; n++) begin
      rand_payload();
      IFID_Rs     = RW'($urandom_range(0, 3));
      IFID_Rt     = RW'($urandom_range(0, 3));
      ID_UsesRt   = 1'($urandom);
      ID_MemRead  = ($urandom_range(0, 2) != 0);
      ID_MemWrite = 1'($urandom);
      ID_RegWrite = 1'($urandom);
      ID_Valid    = ($urandom_range(0, 7) != 0);
      Flush       = ($urandom_range(0, 7) == 0);
      do_cycle("rnd");
    end

    // Reset in the middle of a low phase with a valid instruction in EX.
    drive_instr(1, 0, 0, 0, 0, 1, 2, 3);
    do_cycle("pre_rst0");
    drive_instr(1, 0, 0, 0, 0, 1, 4, 5);
    do_cycle("pre_rst1");
    check("pre_rst.valid", 64'(IDEX_Valid), 64'd1);
    #2 rst = 1'b1;
    m_ex  = '0;
    m_cnt = '0;
    #1;
    check("midrst.Stall", 64'(Stall), 64'd0);
    check_outs("midrst");
    @(negedge clk);
    #2 rst = 1'b0;
    drive_instr(1, 0, 0, 1, 0, 1, 6, 7);
    do_cycle("post_rst");
    check("post_rst.valid", 64'(IDEX_Valid), 64'd1);
    check("post_rst.rt", 64'(IDEX_Rt), 64'd7);

    // Saturation: start the counter just below the ceiling.
    drive_instr(0, 0, 0, 0, 0, 0, 0, 0);
    do_cycle("sat_idle");
    dut.r_stall_count = 16'hFFFE;
    m_cnt = 16'hFFFE;
    for (int k = 0; k < 2; k++) begin
      drive_instr(1, 0, 0, 1, 0, 1, 1, 8);
      do_cycle("sat_lw");
      drive_instr(1, 0, 0, 0, 0, 1, 8, 2);
      do_cycle("sat_add");
      do_cycle("sat_add2");
    end
    check("sat.final", 64'(StallCount), 64'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
